// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//
// Multi-cycle RV64M multiply/divide unit for the execute stage. It takes one
// M-extension op from ID/EX and iterates either a shift-add multiplier or a
// restoring divider, retiring BITS_PER_CYCLE bits per cycle. It stalls the
// pipeline through busy until it raises a one-cycle result strobe.
//
// Handshake: an op is accepted in any cycle where the unit is IDLE, start=1
// and flush=0. busy is raised combinationally in that same cycle and stays
// high through CALC. resValid is high for exactly one cycle (DONE) with
// result valid in that cycle, and busy is low then so the pipeline advances.
// start is ignored outside IDLE; the pipeline must not offer a new op before
// the strobe. flush squashes the op: busy drops at once and the unit returns
// to IDLE on the next edge.
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous reset, active low
//   start     M-op valid from ID/EX
//   op        0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   word      W-form: use bits [31:0], sign-extend the result from bit 31
//   ia, ib    operands rs1, rs2
//   flush     squash the in-flight op (branch redirect)
//   busy      stall request to the pipeline
//   resValid  one-cycle result strobe
//   result    final result, held until the next result is produced
//   state_dbg current FSM state (0 IDLE, 1 CALC, 2 DONE)
//
// Parameters:
//   XLEN            datapath width, only 64 is supported
//   BITS_PER_CYCLE  bits retired per iteration: 1, 2 or 4
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int XLEN           = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] ia,
  input  logic [XLEN-1:0] ib,
  input  logic            flush,
  output logic            busy,
  output logic            resValid,
  output logic [XLEN-1:0] result,
  output logic [1:0]      state_dbg
);

  localparam int B = BITS_PER_CYCLE;
  localparam logic [6:0] CNT64 = 7'(64 / B);
  localparam logic [6:0] CNT32 = 7'(32 / B);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic        word_q, word_d;
  logic        neg_q, neg_d;       // apply negation to the final value
  logic [63:0] a_q, a_d;           // multiplicand or divisor magnitude
  logic [64:0] acc_q, acc_d;       // product high half / partial remainder
  logic [63:0] shf_q, shf_d;       // multiplier bits / dividend->quotient
  logic [63:0] result_q, result_d;

  // -------------------------------------------------------------------------
  // Accept-time operand preparation and special-case detection
  // -------------------------------------------------------------------------
  logic        accept;
  logic        is_div_in;
  logic        sgn_a_in, sgn_b_in;
  logic [63:0] a_ext, b_ext;
  logic        a_neg, b_neg;
  logic [63:0] abs_a, abs_b;
  logic [63:0] dividend_w;
  logic [63:0] min_neg;
  logic        div_zero, div_ovf, special_in;
  logic [63:0] special_val;
  logic        neg_in;

  always_comb begin
    accept    = (state_q == S_IDLE) & start & ~flush;
    is_div_in = op[2];
    // W multiplies only keep the low 32 product bits, so signedness is moot
    // and every W multiply is treated as an unsigned MULW.
    sgn_a_in  = (op == OP_DIV) | (op == OP_REM) |
                (~word & ((op == OP_MULH) | (op == OP_MULHSU)));
    sgn_b_in  = (op == OP_DIV) | (op == OP_REM) | (~word & (op == OP_MULH));

    if (word) begin
      a_ext = sgn_a_in ? {{32{ia[31]}}, ia[31:0]} : {32'd0, ia[31:0]};
      b_ext = sgn_b_in ? {{32{ib[31]}}, ib[31:0]} : {32'd0, ib[31:0]};
    end else begin
      a_ext = ia;
      b_ext = ib;
    end

    a_neg = sgn_a_in & a_ext[63];
    b_neg = sgn_b_in & b_ext[63];
    abs_a = a_neg ? -a_ext : a_ext;
    abs_b = b_neg ? -b_ext : b_ext;

    dividend_w = word ? {{32{ia[31]}}, ia[31:0]} : ia;
    min_neg    = word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;

    div_zero   = is_div_in & (b_ext == 64'd0);
    div_ovf    = ((op == OP_DIV) | (op == OP_REM)) &
                 (a_ext == min_neg) & (b_ext == '1);
    special_in = div_zero | div_ovf;

    // op[1] distinguishes REM/REMU from DIV/DIVU.
    if (div_zero) begin
      special_val = op[1] ? dividend_w : '1;
    end else begin
      special_val = op[1] ? 64'd0 : dividend_w;
    end

    // Remainder follows the dividend sign; everything else is the XOR.
    neg_in = (is_div_in & op[1]) ? a_neg : (a_neg ^ b_neg);
  end

  // -------------------------------------------------------------------------
  // One iteration of the shift-add multiplier: add a*m for the low B
  // multiplier bits into the high half, then shift the whole product right.
  // -------------------------------------------------------------------------
  logic [63+B:0] mul_sum;
  logic [64:0]   mul_acc;
  logic [63:0]   mul_shf;

  always_comb begin
    mul_sum = {{B{1'b0}}, acc_q[63:0]};
    for (int i = 0; i < B; i++) begin
      if (shf_q[i]) begin
        mul_sum = mul_sum + ({{B{1'b0}}, a_q} << i);
      end
    end
    mul_acc = {1'b0, mul_sum[63+B:B]};
    mul_shf = {mul_sum[B-1:0], shf_q[63:B]};
  end

  // -------------------------------------------------------------------------
  // B steps of the restoring divider. The dividend shifts out of the top of
  // shf while quotient bits shift in at the bottom.
  // -------------------------------------------------------------------------
  logic [64:0] div_acc;
  logic [63:0] div_shf;

  always_comb begin
    div_acc = acc_q;
    div_shf = shf_q;
    for (int i = 0; i < B; i++) begin
      div_acc = {div_acc[63:0], div_shf[63]};
      div_shf = {div_shf[62:0], 1'b0};
      if (div_acc >= {1'b0, a_q}) begin
        div_acc    = div_acc - {1'b0, a_q};
        div_shf[0] = 1'b1;
      end
    end
  end

  // Sign fix-up and result selection, applied on the final iteration.
  function automatic logic [63:0] finalize(input logic [2:0]  f_op,
                                           input logic        f_word,
                                           input logic        f_neg,
                                           input logic [63:0] f_hi,
                                           input logic [63:0] f_lo);
    logic [127:0] prod;
    logic [63:0]  val;
    logic [63:0]  res;
    prod = {f_hi, f_lo};
    val  = 64'd0;
    res  = 64'd0;
    if (!f_op[2]) begin
      if (f_word) begin
        // 32 iterations leave the 64-bit product in prod[95:32].
        res = {{32{f_lo[63]}}, f_lo[63:32]};
      end else if (f_op == OP_MUL) begin
        res = prod[63:0];
      end else begin
        prod = f_neg ? -prod : prod;
        res  = prod[127:64];
      end
    end else begin
      val = f_op[1] ? f_hi : f_lo;
      val = f_neg ? -val : val;
      res = f_word ? {{32{val[31]}}, val[31:0]} : val;
    end
    return res;
  endfunction

  // -------------------------------------------------------------------------
  // FSM next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          state_d = special_in ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == 7'd1) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath next values
  // -------------------------------------------------------------------------
  logic [64:0] step_acc;
  logic [63:0] step_shf;

  always_comb begin
    op_d     = op_q;
    word_d   = word_q;
    neg_d    = neg_q;
    a_d      = a_q;
    acc_d    = acc_q;
    shf_d    = shf_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    step_acc = op_q[2] ? div_acc : mul_acc;
    step_shf = op_q[2] ? div_shf : mul_shf;

    if (accept) begin
      op_d   = op;
      word_d = word;
      neg_d  = neg_in;
      cnt_d  = word ? CNT32 : CNT64;
      acc_d  = 65'd0;
      if (is_div_in) begin
        a_d   = abs_b;
        // A W dividend is pre-aligned so its MSB leaves first.
        shf_d = word ? {abs_a[31:0], 32'd0} : abs_a;
      end else begin
        a_d   = abs_a;
        shf_d = abs_b;
      end
      if (special_in) begin
        result_d = special_val;
        cnt_d    = 7'd0;
      end
    end else if (state_q == S_CALC) begin
      if (flush) begin
        cnt_d = 7'd0;
      end else begin
        acc_d = step_acc;
        shf_d = step_shf;
        cnt_d = cnt_q - 7'd1;
        if (cnt_q == 7'd1) begin
          result_d = finalize(op_q, word_q, neg_q, step_acc[63:0], step_shf);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 7'd0;
      op_q     <= 3'd0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      a_q      <= 64'd0;
      acc_q    <= 65'd0;
      shf_q    <= 64'd0;
      result_q <= 64'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      word_q   <= word_d;
      neg_q    <= neg_d;
      a_q      <= a_d;
      acc_q    <= acc_d;
      shf_q    <= shf_d;
      result_q <= result_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    busy      = ~flush & (((state_q == S_IDLE) & start) | (state_q == S_CALC));
    resValid  = (state_q == S_DONE) & ~flush;
    result    = result_q;
    state_dbg = state_q;
  end

endmodule
